// File: rtl/ado_pkg.sv
// Shared constants and helpers for the multichannel amplitude difference operator.
package ado_pkg;

  localparam logic [1:0] ADO_MODE_ABS  = 2'd0;
  localparam logic [1:0] ADO_MODE_RISE = 2'd1;
  localparam logic [1:0] ADO_MODE_FALL = 2'd2;

  // Channel id width; a single channel still needs one bit.
  function automatic int unsigned ado_ch_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic longint unsigned ado_sat_max(input int unsigned bits);
    return (bits >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
  endfunction

endpackage

// File: rtl/ado_delay_bank.sv
// Per-channel K-deep sample history with saturating fill counters.
module ado_delay_bank
  import ado_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned K_DELAY = 3,
  parameter int unsigned CH_W    = ado_ch_w(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          ch,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dly_out,
  output logic                     primed
);

  localparam int unsigned FW = $clog2(K_DELAY + 1);

  logic signed [DATA_W-1:0] line_q [N_CH][K_DELAY];
  logic [FW-1:0]            fill_q [N_CH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        fill_q[c] <= '0;
        for (int k = 0; k < K_DELAY; k++) line_q[c][k] <= '0;
      end
    end else if (wr_en) begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch == CH_W'(c)) begin
          line_q[c][0] <= din;
          for (int k = 1; k < K_DELAY; k++) line_q[c][k] <= line_q[c][k-1];
          if (fill_q[c] != FW'(K_DELAY)) fill_q[c] <= fill_q[c] + FW'(1);
        end
      end
    end
  end

  // Oldest entry is x[n-K] once the channel has seen K samples.
  always_comb begin
    dly_out = '0;
    primed  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch == CH_W'(c)) begin
        primed  = (fill_q[c] == FW'(K_DELAY));
        dly_out = primed ? line_q[c][K_DELAY-1] : '0;
      end
    end
  end

endmodule

// File: rtl/ado_mc.sv
// Time-multiplexed |x[n] - x[n-K]| with rectification modes, threshold events and
// per-channel refractory counters; four-stage pipeline stalled as one by out_ready.
module ado_mc
  import ado_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned K_DELAY  = 3,
  parameter int unsigned OUT_BITS = 16,
  parameter int unsigned SCALE_SH = 0,
  parameter int unsigned REFRAC   = 8,
  parameter int unsigned CH_W     = ado_ch_w(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]          in_ch,
  input  logic [1:0]               mode,
  input  logic [OUT_BITS-1:0]      thresh,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_BITS-1:0]      out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_event,
  output logic                     out_primed
);

  localparam int unsigned MW = DATA_W + 1;
  localparam int unsigned RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  localparam longint unsigned SatMax = ado_sat_max(OUT_BITS);

  logic en, ch_ok, wr;
  logic signed [DATA_W-1:0] dly;
  logic prm;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign ch_ok    = (32'(in_ch) < N_CH);
  assign wr       = in_valid && en && ch_ok;

  ado_delay_bank #(
    .DATA_W  (DATA_W),
    .N_CH    (N_CH),
    .K_DELAY (K_DELAY),
    .CH_W    (CH_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr),
    .ch      (in_ch),
    .din     (in_data),
    .dly_out (dly),
    .primed  (prm)
  );

  logic                     v1_q, v2_q, v3_q, v4_q;
  logic signed [DATA_W-1:0] x1_q, xd1_q;
  logic signed [MW-1:0]     d2_q, d2_d;
  logic [MW-1:0]            m3_q, m3_d, negd, sh;
  logic [OUT_BITS-1:0]      data4_q, data4_d;
  logic [CH_W-1:0]          ch1_q, ch2_q, ch3_q, ch4_q;
  logic [1:0]               mode1_q, mode2_q;
  logic [OUT_BITS-1:0]      th1_q, th2_q, th3_q, th4_q;
  logic                     pr1_q, pr2_q, pr3_q, pr4_q;
  logic                     sat;

  assign d2_d = $signed({x1_q[DATA_W-1], x1_q}) - $signed({xd1_q[DATA_W-1], xd1_q});

  always_comb begin
    negd = -d2_q;
    case (mode2_q)
      ADO_MODE_RISE: m3_d = d2_q[MW-1] ? '0 : d2_q;
      ADO_MODE_FALL: m3_d = d2_q[MW-1] ? negd : '0;
      default:       m3_d = d2_q[MW-1] ? negd : d2_q;
    endcase
  end

  always_comb begin
    sh      = m3_q >> SCALE_SH;
    sat     = (64'(sh) > SatMax);
    data4_d = sat ? '1 : OUT_BITS'(sh);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      v4_q    <= 1'b0;
      x1_q    <= '0;
      xd1_q   <= '0;
      d2_q    <= '0;
      m3_q    <= '0;
      data4_q <= '0;
      ch1_q   <= '0;
      ch2_q   <= '0;
      ch3_q   <= '0;
      ch4_q   <= '0;
      mode1_q <= '0;
      mode2_q <= '0;
      th1_q   <= '0;
      th2_q   <= '0;
      th3_q   <= '0;
      th4_q   <= '0;
      pr1_q   <= 1'b0;
      pr2_q   <= 1'b0;
      pr3_q   <= 1'b0;
      pr4_q   <= 1'b0;
    end else if (en) begin
      // Samples for nonexistent channels enter as bubbles.
      v1_q    <= in_valid && ch_ok;
      x1_q    <= in_data;
      xd1_q   <= dly;
      ch1_q   <= in_ch;
      mode1_q <= mode;
      th1_q   <= thresh;
      pr1_q   <= prm;
      v2_q    <= v1_q;
      d2_q    <= d2_d;
      ch2_q   <= ch1_q;
      mode2_q <= mode1_q;
      th2_q   <= th1_q;
      pr2_q   <= pr1_q;
      v3_q    <= v2_q;
      m3_q    <= m3_d;
      ch3_q   <= ch2_q;
      th3_q   <= th2_q;
      pr3_q   <= pr2_q;
      v4_q    <= v3_q;
      data4_q <= data4_d;
      ch4_q   <= ch3_q;
      th4_q   <= th3_q;
      pr4_q   <= pr3_q;
    end
  end

  logic [RW-1:0] refrac_q [N_CH];
  logic [RW-1:0] refrac_cur, refrac_d;
  logic          ev, xfer;

  always_comb begin
    refrac_cur = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch4_q == CH_W'(c)) refrac_cur = refrac_q[c];
    end
  end

  assign ev       = v4_q && (th4_q != '0) && (data4_q >= th4_q) && (refrac_cur == '0);
  assign xfer     = v4_q && out_ready;
  assign refrac_d = ev ? RW'(REFRAC) : ((refrac_cur != '0) ? refrac_cur - RW'(1) : refrac_cur);

  // Refractory state moves only when the consumer takes the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) refrac_q[c] <= '0;
    end else if (xfer) begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch4_q == CH_W'(c)) refrac_q[c] <= refrac_d;
      end
    end
  end

  assign out_valid  = v4_q;
  assign out_data   = data4_q;
  assign out_ch     = ch4_q;
  assign out_event  = ev;
  assign out_primed = pr4_q;

endmodule

// File: doc/ado_mc.md
Name: ado_mc

Overview:
- Multichannel, time-multiplexed Amplitude Difference Operator: y = |x_c[n] - x_c[n-K_DELAY]|, computed per channel c on an interleaved sample stream.
- Adds valid/ready handshake with backpressure, selectable rectification mode, a threshold event detector and a per-channel refractory counter.
- Sits between the sample front-end and the spike-detection logic, alongside the other non-linear operators.

Parameters:
- DATA_W, 16, signed input sample width
- N_CH, 4, number of interleaved channels (>=1)
- K_DELAY, 3, difference lag in samples of the same channel (>=1)
- OUT_BITS, 16, unsigned output width
- SCALE_SH, 0, right shift applied to the magnitude before saturation
- REFRAC, 8, per-channel refractory length after an event, in that channel's samples (>=0)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts a sample this cycle
- in_data  in  DATA_W  signed sample
- in_ch  in  CH_W=max(1,clog2(N_CH))  channel id of in_data
- mode  in  2  0=abs, 1=rising only, 2=falling only, 3=abs; captured with the sample
- thresh  in  OUT_BITS  event threshold; captured with the sample; 0 disables events
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_BITS  scaled, saturated magnitude
- out_ch  out  CH_W  channel of out_data
- out_event  out  1  threshold event, qualified by out_valid
- out_primed  out  1  channel had >=K_DELAY prior samples

Behaviour:
- Reset: synchronous on rst_n=0. Clears all delay lines, fill counters, refractory counters and pipeline valids. All outputs go to 0; in_ready=1 in the first cycle after release.
- Handshake: en = !out_valid || out_ready. in_ready = en (combinational). Transfer when in_valid&&in_ready. All pipeline stages advance only on en, so a stall holds every stage and every output stable.
- Latency: exactly 4 en-cycles from acceptance to out_valid. Full throughput of 1 sample per cycle when out_ready=1.
- S1: read x_c[n-K] from the channel-c delay line; shift in in_data for channel c only. Other channels are untouched. If the channel fill count < K_DELAY, the delayed value is 0 and primed=0. The fill count saturates at K_DELAY.
- S2: d = in - delayed, signed DATA_W+1. No overflow is possible.
- S3: m = |d| for mode 0/3; max(d,0) for mode 1; max(-d,0) for mode 2. m is unsigned DATA_W+1 bits.
- S4: s = m >> SCALE_SH; out_data = (s > 2^OUT_BITS-1) ? all-ones : s.
- Event: out_event = (thresh != 0) && (out_data >= thresh) && (refrac_c == 0).
  - On event: refrac_c <= REFRAC.
  - Otherwise, on each channel-c result transfer, refrac_c decrements if nonzero.
  - Counters update on the output transfer, not on production.
  - REFRAC=0 allows an event on every qualifying sample.
- Invalid channel (in_ch >= N_CH): the sample is accepted but dropped. No state change and no output.
- Back-to-back samples of the same channel: S1 reads the delay line after any previous write to it, so there is no hazard. The shift-register bank updates in one cycle.
- Reset mid-stream: in-flight results are discarded and no out_valid follows.

Decomposition:
- ado_pkg holds:
  - mode localparams: ADO_MODE_ABS, ADO_MODE_RISE, ADO_MODE_FALL
  - clog2-based CH_W helper function
  - the saturation-max expression
- Sub-module ado_delay_bank (N_CH x K_DELAY shift registers, fill counters, primed flag) with ports: clk, rst_n, wr_en, ch, din, dly_out, primed.
- Top level holds the pipeline, mode, scaling, saturation, event and refractory logic.

Test Plan:
- Single channel, N_CH=1, K=3, mode 0, SCALE_SH=0, out_ready=1; inputs 0,0,0,100,-100,0 -> outputs appear 4 cycles after each input:
  - values 0,0,0,100,100,0
  - out_primed=0 for the first 3 samples, then 1
- Extremes at DATA_W=16, OUT_BITS=16: x[n-3]=-32768, x[n]=32767 -> m=65535, out_data=65535.
  - Same with OUT_BITS=8, SCALE_SH=4 -> s=4095, saturates to out_data=255.
- Modes, with a step of +50 followed 3 samples later by a drop of -50:
  - mode 1 -> out_data 50 then 0
  - mode 2 -> 0 then 50
  - mode 3 matches mode 0
- Interleave, N_CH=2, channels alternating 0,1:
  - ch0 samples 10,20,30,40; ch1 constant 7
  - -> ch0 fourth result=30, ch1 results=0 once primed
  - out_ch tracks input order
- Backpressure: random out_ready with 1 sample/cycle offered -> no loss or duplication; out_data held stable while out_valid && !out_ready; in_ready low exactly when stalled.
- Events and reset, REFRAC=2, thresh=40, magnitudes 50,50,50,50 on ch0:
  - out_event = 1,0,0,1
  - thresh=0 -> no events
  - rst_n pulsed low mid-stream -> out_valid=0 next cycle; refractory and fill state cleared (out_primed=0 again)
